// File: rtl/axi_lite_wr_arbiter.sv
// Two-master AXI-Lite write arbiter (AW/W/B) sharing one slave port.
// Grants are round-robin, cover a whole transaction, and a B-channel watchdog returns SLVERR.
module axi_lite_wr_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [1:0]          m0_bresp,

    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,

    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,

    output logic [1:0]          grant,
    output logic                late_resp
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP,
        ERR
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       grant_n;
    logic             last_owner;
    logic             last_owner_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             aw_done;
    logic             aw_done_n;
    logic             w_done;
    logic             w_done_n;
    logic             late_resp_n;

    logic             own1;
    logic             o_awvalid;
    logic             o_wvalid;
    logic             o_bready;
    logic             o_awready;
    logic             o_wready;
    logic             o_bvalid;
    logic [1:0]       o_bresp;
    logic             aw_fin;
    logic             w_fin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

    // Owner selection: last_owner = 1 means m1 finished last, so m0 wins a tie.
    assign own1      = grant[1];
    assign o_awvalid = own1 ? m1_awvalid : m0_awvalid;
    assign o_wvalid  = own1 ? m1_wvalid  : m0_wvalid;
    assign o_bready  = own1 ? m1_bready  : m0_bready;

    assign s_awaddr = grant[1] ? m1_awaddr : (grant[0] ? m0_awaddr : '0);
    assign s_wdata  = grant[1] ? m1_wdata  : (grant[0] ? m0_wdata  : '0);
    assign s_wstrb  = grant[1] ? m1_wstrb  : (grant[0] ? m0_wstrb  : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            cnt        <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            late_resp  <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_owner <= last_owner_n;
            cnt        <= cnt_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
            late_resp  <= late_resp_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_owner_n = last_owner;
        cnt_n        = cnt;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        late_resp_n  = late_resp;
        s_awvalid    = 1'b0;
        s_wvalid     = 1'b0;
        s_bready     = 1'b0;
        o_awready    = 1'b0;
        o_wready     = 1'b0;
        o_bvalid     = 1'b0;
        o_bresp      = 2'b00;
        aw_fin       = 1'b0;
        w_fin        = 1'b0;

        case (state)
            IDLE: begin
                // Responses with no owner are drained and flagged, never forwarded.
                s_bready = 1'b1;
                if (s_bvalid) begin
                    late_resp_n = 1'b1;
                end
                if (m0_awvalid && m1_awvalid) begin
                    grant_n = last_owner ? 2'b01 : 2'b10;
                end else if (m0_awvalid) begin
                    grant_n = 2'b01;
                end else if (m1_awvalid) begin
                    grant_n = 2'b10;
                end
                if (m0_awvalid || m1_awvalid) begin
                    state_n = XFER;
                end
            end
            XFER: begin
                s_awvalid = o_awvalid & ~aw_done;
                s_wvalid  = o_wvalid & ~w_done;
                o_awready = s_awready & ~aw_done;
                o_wready  = s_wready & ~w_done;
                aw_fin    = aw_done | (s_awvalid & s_awready);
                w_fin     = w_done | (s_wvalid & s_wready);
                if (aw_fin && w_fin) begin
                    state_n   = RESP;
                    cnt_n     = '0;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else begin
                    aw_done_n = aw_fin;
                    w_done_n  = w_fin;
                end
            end
            RESP: begin
                o_bvalid = s_bvalid;
                o_bresp  = s_bresp;
                s_bready = o_bready;
                if (s_bvalid) begin
                    if (o_bready) begin
                        last_owner_n = own1;
                        grant_n      = 2'b00;
                        state_n      = IDLE;
                    end
                end else begin
                    cnt_n = sat_inc(cnt);
                    if ((TIMEOUT != 0) && (cnt_n == CNT_TMO)) begin
                        state_n = ERR;
                    end
                end
            end
            ERR: begin
                o_bvalid = 1'b1;
                o_bresp  = RESP_SLVERR;
                if (o_bready) begin
                    last_owner_n = own1;
                    grant_n      = 2'b00;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 2'b00;
            end
        endcase
    end

    assign m0_awready = grant[0] & o_awready;
    assign m1_awready = grant[1] & o_awready;
    assign m0_wready  = grant[0] & o_wready;
    assign m1_wready  = grant[1] & o_wready;
    assign m0_bvalid  = grant[0] & o_bvalid;
    assign m1_bvalid  = grant[1] & o_bvalid;
    assign m0_bresp   = grant[0] ? o_bresp : 2'b00;
    assign m1_bresp   = grant[1] ? o_bresp : 2'b00;

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Bench for axi_lite_wr_arbiter: arbitration vector table, directed corner sequences,
// and randomized transactions checked against a round-robin reference rule.
module tb_axi_lite_wr_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  awv;
    logic [1:0]  awr;
    logic [11:0] awaddr [2];
    logic [1:0]  wv;
    logic [1:0]  wr;
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bv;
    logic [1:0]  br;
    logic [1:0]  bresp [2];
    logic        s_awvalid, s_awready;
    logic [11:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic [1:0]  grant;
    logic        late_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_lite_wr_arbiter #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_awvalid(awv[0]), .m0_awready(awr[0]), .m0_awaddr(awaddr[0]),
        .m0_wvalid(wv[0]), .m0_wready(wr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
        .m0_bvalid(bv[0]), .m0_bready(br[0]), .m0_bresp(bresp[0]),
        .m1_awvalid(awv[1]), .m1_awready(awr[1]), .m1_awaddr(awaddr[1]),
        .m1_wvalid(wv[1]), .m1_wready(wr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
        .m1_bvalid(bv[1]), .m1_bready(br[1]), .m1_bresp(bresp[1]),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .grant(grant), .late_resp(late_resp)
    );

    typedef struct {
        int         prev;
        logic [1:0] req;
        logic [1:0] exp_grant;
    } arb_vec_t;

    arb_vec_t arb_tab [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        awv = 2'b00; wv = 2'b00; br = 2'b00;
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One complete transaction by master m while this bench plays the slave.
    // b_dly < 0: slave never responds, so the watchdog must answer.
    task automatic run_txn(input int m, input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int w_lead,
                           input int aw_dly, input int b_dly, input int br_dly, input bit other_req);
        int o = 1 - m;
        int cyc = 0;
        int awc = 0;
        int wc = 0;
        int sv_seen = 0;
        int b_wait = 0;
        int bv_seen = 0;
        int hs_cyc = -1;
        int bv_cyc = -1;
        int other_bad = 0;
        int grant_bad = 0;
        bit m_aw_done = 0, m_w_done = 0, s_aw_done = 0, s_w_done = 0, s_b_done = 0, fin = 0;
        logic [1:0] exp_resp;
        logic [1:0] got_resp = 2'b11;
        exp_resp = (b_dly < 0) ? 2'b10 : resp;
        awaddr[m] = addr; wdata[m] = data; wstrb[m] = strb; s_bresp = resp;
        while (!fin && cyc < 200) begin
            awv[m]    = (cyc >= w_lead) && !m_aw_done;
            wv[m]     = !m_w_done;
            awv[o]    = other_req && (cyc >= w_lead);
            s_awready = (sv_seen >= aw_dly);
            s_wready  = 1'b1;
            s_bvalid  = s_aw_done && s_w_done && (b_dly >= 0) && (b_wait >= b_dly) && !s_b_done;
            br[m]     = (bv_seen >= br_dly);
            @(negedge clk);
            if (grant != 2'b00 && grant != (2'b01 << m)) grant_bad++;
            if (awr[o] || wr[o] || bv[o]) other_bad++;
            if (s_awvalid) begin
                if (s_awready) begin
                    awc++;
                    s_aw_done = 1;
                    check("aw_addr", s_awaddr, addr);
                end else begin
                    sv_seen++;
                end
            end
            if (s_wvalid && s_wready) begin
                wc++;
                s_w_done = 1;
                check("w_data", s_wdata, data);
                check("w_strb", s_wstrb, strb);
            end
            if (s_aw_done && s_w_done) begin
                if (hs_cyc < 0) hs_cyc = cyc;
                else b_wait++;
            end
            if (s_bvalid && s_bready) s_b_done = 1;
            if (bv[m]) begin
                if (bv_cyc < 0) bv_cyc = cyc;
                check("s_bready_follow", s_bready, (b_dly >= 0) ? br[m] : 1'b0);
                if (br[m]) begin
                    got_resp = bresp[m];
                    fin = 1;
                end else begin
                    bv_seen++;
                end
            end
            if (awv[m] && awr[m]) m_aw_done = 1;
            if (wv[m] && wr[m]) m_w_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        awv[m] = 1'b0; wv[m] = 1'b0; br[m] = 1'b0;
        s_bvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        check("txn_complete", fin, 1);
        check("aw_handshakes", awc, 1);
        check("w_handshakes", wc, 1);
        check("b_resp", got_resp, exp_resp);
        check("grant_owner", grant_bad, 0);
        check("nonowner_quiet", other_bad, 0);
        if (b_dly < 0) check("timeout_latency", bv_cyc - hs_cyc, TMO + 1);
        @(negedge clk);
        check("grant_release", grant, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "global timeout");
    end

    initial begin
        int last;
        int winner;
        int req;

        arb_tab[0] = '{2, 2'b01, 2'b01};
        arb_tab[1] = '{2, 2'b10, 2'b10};
        arb_tab[2] = '{2, 2'b11, 2'b01};
        arb_tab[3] = '{0, 2'b11, 2'b10};
        arb_tab[4] = '{1, 2'b11, 2'b01};
        arb_tab[5] = '{0, 2'b01, 2'b01};
        arb_tab[6] = '{2, 2'b00, 2'b00};
        arb_tab[7] = '{1, 2'b10, 2'b10};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_s_awvalid", s_awvalid, 0);
        check("rst_s_wvalid", s_wvalid, 0);
        check("rst_m_awready", awr, 2'b00);
        check("rst_m_wready", wr, 2'b00);
        check("rst_m_bvalid", bv, 2'b00);
        check("rst_late", late_resp, 0);
        check("rst_s_awaddr", s_awaddr, 12'h000);

        // Arbitration decision table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (arb_tab[i].prev < 2)
                run_txn(arb_tab[i].prev, 12'h100, 32'h1234_0000 + i, 4'hF, 2'b00, 0, 0, 0, 0, 0);
            awv = arb_tab[i].req; wv = 2'b00; s_awready = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check("arb_grant", grant, arb_tab[i].exp_grant);
            check("arb_s_awvalid", s_awvalid, |arb_tab[i].exp_grant);
        end

        // Single write from m0
        do_reset();
        run_txn(0, 12'h000, 32'hA5A5_A5A5, 4'hF, 2'b00, 0, 0, 0, 0, 0);

        // Four back-to-back ties alternate m0, m1, m0, m1
        do_reset();
        wdata[1] = 32'hDEAD_0001;
        for (int i = 0; i < 4; i++)
            run_txn(i % 2, 12'(16 * i + 4), 32'hC0DE_0000 + i, 4'(1 << i), 2'(i), 0, 0, 1, 0, 1);
        awv = 2'b00;

        // W leads AW by 3 cycles, slave delays awready by 2
        do_reset();
        run_txn(1, 12'h010, 32'hFFFF_FFFF, 4'hF, 2'b00, 3, 2, 0, 0, 0);

        // m1 back-pressures B for 5 cycles while m0 keeps requesting
        do_reset();
        run_txn(0, 12'h020, 32'h0000_0020, 4'h3, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 12'h024, 32'h0000_0024, 4'hC, 2'b01, 0, 0, 0, 5, 1);
        run_txn(0, 12'h028, 32'h0000_0028, 4'hF, 2'b00, 0, 0, 0, 0, 0);

        // Watchdog, then a stray response in IDLE
        run_txn(0, 12'h030, 32'h0000_0030, 4'hF, 2'b00, 0, 0, -1, 0, 0);
        check("late_before", late_resp, 0);
        s_bvalid = 1'b1; s_bresp = 2'b01;
        #1;
        check("late_s_bready", s_bready, 1);
        check("late_no_bvalid", bv, 2'b00);
        @(posedge clk); #1;
        s_bvalid = 1'b0;
        @(negedge clk);
        check("late_set", late_resp, 1);

        // Reset after AW handshake, before W
        run_txn(0, 12'h040, 32'h0000_0040, 4'hF, 2'b00, 0, 0, 0, 0, 0);
        awaddr[1] = 12'h0F0; awv = 2'b10; wv = 2'b00; s_awready = 1'b1; s_wready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_aw_pending", s_awvalid, 1);
        @(posedge clk); #1;
        check("mid_aw_taken", s_awvalid, 0);
        reset = 1'b1; awv = 2'b00; s_awready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_s_awvalid", s_awvalid, 0);
        check("mid_rst_s_wvalid", s_wvalid, 0);
        check("mid_rst_bvalid", bv, 2'b00);
        check("mid_rst_late", late_resp, 0);
        run_txn(0, 12'h050, 32'h0000_0050, 4'hF, 2'b00, 0, 0, 0, 0, 1);
        awv = 2'b00;

        // Random transactions against the round-robin rule
        do_reset();
        last = 1;
        for (int i = 0; i < 24; i++) begin
            req = int'($urandom_range(1, 3));
            if (req == 3) winner = 1 - last;
            else winner = (req == 1) ? 0 : 1;
            run_txn(winner, 12'($urandom), $urandom, 4'($urandom), 2'($urandom),
                    (req == 3) ? 0 : int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), req == 3);
            awv = 2'b00;
            last = winner;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_wr_arbiter.md
Name: axi_lite_wr_arbiter

Overview:
- Two-master, one-slave AXI-Lite write-channel arbiter (AW/W/B only).
- Shares a single peripheral write port, e.g. the GPIO slave port of the interconnect, between the CPU path and a second requester (DMA/debug).
- Grants are round-robin and whole-transaction: one grant covers a full AW + W + B sequence.
- A response watchdog ensures a dead slave cannot hang either master.

Parameters:
- ADDR_W, 12, address width of AW channel.
- DATA_W, 32, write data width; strobe width is DATA_W/8.
- TIMEOUT, 256, max cycles waiting for s_bvalid after AW and W have both completed; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- m0_awvalid / m1_awvalid  input  1 each  master write-address valid; also acts as the arbitration request.
- m0_awready / m1_awready  output  1 each  address accepted.
- m0_awaddr / m1_awaddr  input  ADDR_W each  write address.
- m0_wvalid / m1_wvalid  input  1 each  write-data valid.
- m0_wready / m1_wready  output  1 each  write data accepted.
- m0_wdata / m1_wdata  input  DATA_W each  write data.
- m0_wstrb / m1_wstrb  input  DATA_W/8 each  byte strobes.
- m0_bvalid / m1_bvalid  output  1 each  write response valid.
- m0_bready / m1_bready  input  1 each  response accepted.
- m0_bresp / m1_bresp  output  2 each  response code.
- s_awvalid / s_awready / s_awaddr  out / in / out  1 / 1 / ADDR_W  slave address channel.
- s_wvalid / s_wready / s_wdata / s_wstrb  out / in / out / out  1 / 1 / DATA_W / DATA_W/8  slave data channel.
- s_bvalid / s_bready / s_bresp  in / out / in  1 / 1 / 2  slave response channel.
- grant  output  2  one-hot owner: 01 = m0, 10 = m1, 00 = none.
- late_resp  output  1  sticky; set when a slave response arrives with no owner.

Behaviour:
Reset (sync, reset = 1):
- state = IDLE, grant = 00, last_owner = m1 (so m0 wins the first tie), timeout counter = 0, aw_done = w_done = 0, late_resp = 0.
- All valid/ready outputs low; s_awaddr, s_wdata, s_wstrb, m*_bresp = 0.
- Reset mid-transaction aborts it. Masters must also be reset.

IDLE:
- s_bready = 1; any s_bvalid seen here is dropped and sets late_resp.
- If only one m*_awvalid is high, grant that master.
- If both are high, grant the master that is not last_owner.
- The grant register updates at the clock edge, then state goes to XFER. Minimum request-to-s_awvalid latency is 1 cycle.

XFER:
- The owner's AW and W signals pass combinationally to s_*; s_awready/s_wready route back to the owner only. The non-owner sees all readies and bvalid at 0.
- s_awvalid = owner awvalid & !aw_done; s_wvalid = owner wvalid & !w_done.
- aw_done and w_done each set on their handshake. AW and W may complete in either order or in the same cycle.
- When both are done (including both handshakes in the same cycle), go to RESP, clear the counter, clear the done flags.

RESP:
- s_bvalid/s_bresp pass to the owner's m*_bvalid/m*_bresp; s_bready = owner bready.
- On s_bvalid & owner bready: last_owner = owner, grant = 00, go to IDLE. A new grant is possible on the next edge, so transactions are back-to-back every 1 idle cycle.
- The counter increments each cycle without s_bvalid. If TIMEOUT != 0 and the counter reaches TIMEOUT, go to ERR.

ERR:
- Owner sees bvalid = 1, bresp = 2'b10 (SLVERR); s_bready = 0.
- On owner bready: update last_owner, go to IDLE.

Invariants:
- At most one master is owner.
- No combinational path from m*_awvalid to m*_awready in IDLE.
- The watchdog counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Test Plan:
- Single write: m0 writes 0xA5A5A5A5 to 0x000, wstrb 0xF, slave bresp 00 -> s_awaddr = 0x000, s_wdata = 0xA5A5A5A5, m0_bresp = 00, grant returns to 00, m1 sees no readies.
- Simultaneous requests: m0 and m1 both request repeatedly for 4 transactions -> owner order m0, m1, m0, m1; the data of each lands on the slave unmixed.
- W before AW: m1 asserts wvalid with 0xFFFFFFFF 3 cycles before awvalid; slave delays awready by 2 cycles -> exactly one s_awvalid and one s_wvalid handshake each, then one m1 bresp.
- Timeout: TIMEOUT = 8, slave never asserts bvalid -> m0_bvalid with bresp = 10 exactly 8 cycles after RESP entry. A later s_bvalid in IDLE sets late_resp = 1 and does not reach any master.
- Reset mid-XFER: assert reset after the AW handshake but before W -> next cycle grant = 00, all valids low, late_resp = 0. The next tie goes to m0.
- Backpressure: m1 holds bready = 0 for 5 cycles during RESP -> s_bready stays 0, s_bvalid is held, m0 request is not granted until the m1 B handshake completes.
